// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C read/write target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        TX_BYTE  = 3'd3,
        TX_ACK   = 3'd4,
        RX_BYTE  = 3'd5,
        RX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_rw_state_t;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    // Bit counter never wraps: it sticks at 8 until explicitly cleared.
    function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
        return (cnt >= 4'd8) ? 4'd8 : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/i2c_if.sv
// Board-level I2C bus: sda is the resolved wired-AND level, sda_oe pulls it low.
interface i2c_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport slave (input scl, input sda, output sda_oe);
endinterface

// File: rtl/i2c_cond_detect.sv
// SDA/SCL synchronizers plus SCL edge and START/STOP condition detection.
module i2c_cond_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_pulse,
    output logic stop_pulse,
    output logic busy
);
    import i2c_pkg::*;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;
    logic busy_q, busy_d;
    logic scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise    = scl_s & ~scl_prev_q;
    assign scl_fall    = ~scl_s & scl_prev_q;
    assign start_pulse = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_pulse  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign busy        = busy_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        busy_d     = busy_q;
        if (start_pulse) begin
            busy_d = 1'b1;
        end else if (stop_pulse) begin
            busy_d = 1'b0;
        end
    end

    // Chains reset to the idle-high bus level so leaving reset creates no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: rtl/i2c_slave_rw.sv
// I2C target with master-read (from TX FIFO) and master-write (to RX FIFO) bursts.
module i2c_slave_rw #(
    parameter logic [6:0] SLAVE_ADDR   = 7'h42,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] FILL_BYTE    = 8'hFF,
    parameter bit         NACK_ON_FULL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    i2c_if.slave       i2c,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_rd_en,
    input  logic       rx_full,
    output logic       rx_wr_en,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       addr_hit,
    output logic       tx_underrun,
    output logic       rx_overflow
);
    import i2c_pkg::*;

    localparam logic [2:0] S_IDLE     = 3'(IDLE);
    localparam logic [2:0] S_ADDR     = 3'(ADDR);
    localparam logic [2:0] S_ADDR_ACK = 3'(ADDR_ACK);
    localparam logic [2:0] S_TX_BYTE  = 3'(TX_BYTE);
    localparam logic [2:0] S_TX_ACK   = 3'(TX_ACK);
    localparam logic [2:0] S_RX_BYTE  = 3'(RX_BYTE);
    localparam logic [2:0] S_RX_ACK   = 3'(RX_ACK);

    logic       sda_s, scl_rise, scl_fall, start_pulse, stop_pulse;
    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic       tx_rd_en_q, tx_rd_en_d;
    logic       rx_wr_en_q, rx_wr_en_d;
    logic       addr_hit_q, addr_hit_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       rx_overflow_q, rx_overflow_d;
    logic       tx_load;
    logic [7:0] tx_byte;

    i2c_cond_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_in      (i2c.scl),
        .sda_in      (i2c.sda),
        .sda_s       (sda_s),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .busy        (busy)
    );

    assign i2c.sda_oe  = sda_oe_q;
    assign tx_rd_en    = tx_rd_en_q;
    assign rx_wr_en    = rx_wr_en_q;
    assign rx_data     = rx_data_q;
    assign addr_hit    = addr_hit_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_overflow = rx_overflow_q;
    assign tx_byte     = tx_valid ? tx_data : FILL_BYTE;

    // In the ACK states bit_cnt is reused as a phase marker (0 = first falling edge).
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        sda_oe_d      = sda_oe_q;
        rw_d          = rw_q;
        tx_rd_en_d    = 1'b0;
        rx_wr_en_d    = 1'b0;
        addr_hit_d    = 1'b0;
        tx_underrun_d = 1'b0;
        rx_overflow_d = 1'b0;
        tx_load       = 1'b0;
        if (start_pulse) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_pulse) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_inc(bit_cnt_q);
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[6:0] == SLAVE_ADDR) begin
                            addr_hit_d = 1'b1;
                            rw_d       = sda_s;
                            state_d    = S_ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd1;
                    end else if (rw_q == I2C_RW_READ) begin
                        tx_load = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_TX_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_inc(bit_cnt_q);
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        tx_load = 1'b1;
                    end
                end
                S_RX_BYTE: if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_inc(bit_cnt_q);
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_RX_ACK;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        if (!rx_full) begin
                            rx_wr_en_d = 1'b1;
                            rx_data_d  = shift_q;
                            sda_oe_d   = 1'b1;
                        end else begin
                            rx_overflow_d = 1'b1;
                            sda_oe_d      = ~NACK_ON_FULL;
                        end
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_RX_BYTE;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
            // Byte start: the MSB goes out on the same falling edge that ends the ACK.
            if (tx_load) begin
                shift_d       = tx_byte;
                sda_oe_d      = ~tx_byte[7];
                bit_cnt_d     = 4'd1;
                tx_rd_en_d    = tx_valid;
                tx_underrun_d = ~tx_valid;
                state_d       = S_TX_BYTE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'd0;
            rx_data_q     <= 8'd0;
            sda_oe_q      <= 1'b0;
            rw_q          <= I2C_RW_WRITE;
            tx_rd_en_q    <= 1'b0;
            rx_wr_en_q    <= 1'b0;
            addr_hit_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            sda_oe_q      <= sda_oe_d;
            rw_q          <= rw_d;
            tx_rd_en_q    <= tx_rd_en_d;
            rx_wr_en_q    <= rx_wr_en_d;
            addr_hit_q    <= addr_hit_d;
            tx_underrun_q <= tx_underrun_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_rw.sv
// Directed bench for i2c_slave_rw: bit-banged master, TX FIFO model, RX scoreboard.
module tb_i2c_slave_rw;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl, m_sda;
    logic       rx_full;
    logic       tx_rd_en, rx_wr_en, busy, addr_hit, tx_underrun, rx_overflow;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic [7:0] tx_fifo [0:15];
    int         tx_len = 0;
    int         tx_rd_ptr = 0;
    logic [7:0] rx_obs [0:63];
    int         rx_obs_n = 0;
    int         hit_n = 0, und_n = 0, ovf_n = 0;

    logic [7:0] rx_exp [$];
    logic [7:0] tx_exp [$];
    int         rx_chk_idx = 0;
    int         tests = 0, fails = 0;
    int         hit0, rd0, und0, ovf0, push0;

    i2c_if bus ();
    assign bus.scl = m_scl;
    assign bus.sda = m_sda & ~bus.sda_oe;

    assign tx_valid = (tx_rd_ptr < tx_len);
    assign tx_data  = tx_fifo[tx_rd_ptr[3:0]];

    i2c_slave_rw dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2c         (bus),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_rd_en    (tx_rd_en),
        .rx_full     (rx_full),
        .rx_wr_en    (rx_wr_en),
        .rx_data     (rx_data),
        .busy        (busy),
        .addr_hit    (addr_hit),
        .tx_underrun (tx_underrun),
        .rx_overflow (rx_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_rd_en) tx_rd_ptr <= tx_rd_ptr + 1;
    end

    always @(negedge clk) begin
        if (rx_wr_en) begin
            rx_obs[rx_obs_n[5:0]] <= rx_data;
            rx_obs_n <= rx_obs_n + 1;
        end
        if (addr_hit)    hit_n <= hit_n + 1;
        if (tx_underrun) und_n <= und_n + 1;
        if (rx_overflow) ovf_n <= ovf_n + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b, output logic seen);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        seen  = bus.sda; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic v, dummy;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, v);
            b[i] = v;
        end
        send_bit(nack, dummy);
    endtask

    task automatic snap();
        hit0 = hit_n; rd0 = tx_rd_ptr; und0 = und_n; ovf0 = ovf_n; push0 = rx_obs_n;
    endtask

    task automatic check_rx();
        logic [7:0] e;
        while (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            check("rx_push_seen", 32'(rx_obs_n > rx_chk_idx), 1);
            if (rx_obs_n > rx_chk_idx) check("rx_data", rx_obs[rx_chk_idx[5:0]], e);
            rx_chk_idx++;
        end
    endtask

    initial begin
        logic       ack, bit_v;
        logic [7:0] b;
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rx_full = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_rd_en, rx_wr_en, addr_hit, tx_underrun, rx_overflow}, 0);
        check("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        wait_q();

        // Write burst 0xA5, 0x3C
        snap();
        i2c_start();
        check("t1_busy", busy, 1);
        send_byte(8'h84, ack); check("t1_addr_ack", ack, 0);
        rx_exp.push_back(8'hA5); send_byte(8'hA5, ack); check("t1_d0_ack", ack, 0);
        rx_exp.push_back(8'h3C); send_byte(8'h3C, ack); check("t1_d1_ack", ack, 0);
        i2c_stop();
        check("t1_busy_off", busy, 0);
        check("t1_addr_hit", hit_n - hit0, 1);
        check("t1_push_cnt", rx_obs_n - push0, 2);
        check_rx();

        // Read burst from FIFO: ACK then NACK
        tx_fifo[tx_len[3:0]] = 8'h12; tx_len++;
        tx_fifo[tx_len[3:0]] = 8'h34; tx_len++;
        tx_exp.push_back(8'h12); tx_exp.push_back(8'h34);
        snap();
        i2c_start();
        send_byte(8'h85, ack); check("t2_addr_ack", ack, 0);
        recv_byte(1'b0, b); check("t2_byte0", b, tx_exp.pop_front());
        recv_byte(1'b1, b); check("t2_byte1", b, tx_exp.pop_front());
        check("t2_released", bus.sda_oe, 0);
        i2c_stop();
        check("t2_rd_cnt", tx_rd_ptr - rd0, 2);
        check("t2_underrun", und_n - und0, 0);
        check("t2_addr_hit", hit_n - hit0, 1);

        // Read from an empty FIFO
        tx_exp.push_back(8'hFF);
        snap();
        i2c_start();
        send_byte(8'h85, ack); check("t3_addr_ack", ack, 0);
        recv_byte(1'b1, b); check("t3_fill", b, tx_exp.pop_front());
        i2c_stop();
        check("t3_underrun", und_n - und0, 1);
        check("t3_rd_cnt", tx_rd_ptr - rd0, 0);

        // Foreign address
        snap();
        i2c_start();
        send_byte(8'h90, ack); check("t4_addr_nack", ack, 1);
        send_byte(8'h11, ack); check("t4_data_nack", ack, 1);
        i2c_stop();
        check("t4_addr_hit", hit_n - hit0, 0);
        check("t4_push_cnt", rx_obs_n - push0, 0);
        check("t4_fifo_act", (tx_rd_ptr - rd0) + (und_n - und0) + (ovf_n - ovf0), 0);

        // RX FIFO full
        rx_full = 1'b1;
        snap();
        i2c_start();
        send_byte(8'h84, ack); check("t5_addr_ack", ack, 0);
        send_byte(8'h77, ack); check("t5_data_nack", ack, 1);
        i2c_stop();
        rx_full = 1'b0;
        check("t5_overflow", ovf_n - ovf0, 1);
        check("t5_push_cnt", rx_obs_n - push0, 0);

        // Write, repeated START into read, reset mid-read
        snap();
        i2c_start();
        send_byte(8'h84, ack); check("t6_addr_ack", ack, 0);
        rx_exp.push_back(8'h55); send_byte(8'h55, ack); check("t6_d0_ack", ack, 0);
        i2c_rstart();
        tx_fifo[tx_len[3:0]] = 8'hC3; tx_len++;
        send_byte(8'h85, ack); check("t6_sr_addr_ack", ack, 0);
        send_bit(1'b1, bit_v); check("t6_bit7", bit_v, 1);
        send_bit(1'b1, bit_v); check("t6_bit6", bit_v, 1);
        check("t6_driving", bus.sda_oe, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda", bus.sda_oe, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_pulses", {tx_rd_en, rx_wr_en, addr_hit, tx_underrun, rx_overflow}, 0);
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_addr_hit", hit_n - hit0, 2);
        check("t6_rd_cnt", tx_rd_ptr - rd0, 1);
        check_rx();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_q();
        i2c_stop();
        check("t6_idle_busy", busy, 0);

        // Recovery after reset
        snap();
        i2c_start();
        send_byte(8'h84, ack); check("t7_addr_ack", ack, 0);
        i2c_stop();
        check("t7_addr_hit", hit_n - hit0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rw.md
Name: i2c_slave_rw

Overview:
Parametrised I2C target (slave) supporting both master-read and master-write transfers, with multi-byte bursts and repeated START.
Read data comes from a TX FIFO; write data is pushed into an RX FIFO.
Start/stop detection runs on synchronized SDA/SCL through a dedicated sub-module, with a configurable synchronizer depth.
Sits between the board-level i2c_if bus and the system-side FIFOs, one instance per target address.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit target address matched after START.
SYNC_STAGES, 2, flops in each SDA/SCL synchronizer chain (legal range 2..4).
FILL_BYTE, 8'hFF, byte transmitted when the TX FIFO is empty at a read byte boundary.
NACK_ON_FULL, 1, 1 = NACK a written byte when rx_full; 0 = ACK it and drop it.

Ports:
clk  in  1  module clock, at least 8x SCL rate
rst_n  in  1  asynchronous active-low reset
i2c  modport  -  i2c_if.slave bus (SDA open-drain, SCL input only)
tx_valid  in  1  TX FIFO has data
tx_data  in  8  TX FIFO head byte
tx_rd_en  out  1  one-cycle pop of TX FIFO
rx_full  in  1  RX FIFO full
rx_wr_en  out  1  one-cycle push to RX FIFO
rx_data  out  8  byte being pushed; valid when rx_wr_en=1
busy  out  1  high from START to STOP while the bus is owned by any master
addr_hit  out  1  one-cycle pulse when the address matches (either R/W)
tx_underrun  out  1  one-cycle pulse when FILL_BYTE is substituted
rx_overflow  out  1  one-cycle pulse when a written byte is refused or dropped

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; SDA released (out_en=0).
  - tx_rd_en, rx_wr_en, addr_hit, tx_underrun, rx_overflow, busy all 0.
  - rx_data=0; bit counter=0; synchronizers set to 1.
  - Reset mid-transfer releases SDA within the same cycle. The block then ignores the bus until the next START.
- Sampling:
  - Bits are sampled on the synchronized SCL rising edge, using the synchronized SDA.
  - SDA is driven or changed only on the synchronized SCL falling edge. It never changes while SCL=1.
- START/STOP:
  - START = SDA falling while SCL=1. STOP = SDA rising while SCL=1.
  - Both are detected in every state.
  - START in any state, including a repeated START: go to ADDR, clear the bit counter, release SDA.
  - STOP in any state: go to IDLE, release SDA.
- State machine:
  - IDLE: on START -> ADDR.
  - ADDR: shift in 8 bits, MSB first. After the 8th rising edge, compare bits [7:1] with SLAVE_ADDR.
    - Match: pulse addr_hit and go to ADDR_ACK.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: drive SDA=0 from the falling edge after bit 8 until the next falling edge, then branch on R/W: bit0=1 -> TX_BYTE, bit0=0 -> RX_BYTE. The address is ACKed even if FIFOs are empty or full.
  - TX_BYTE: at byte start (the same falling edge that ends the ACK), latch the byte to send.
    - tx_valid=1: latch tx_data and pulse tx_rd_en once.
    - tx_valid=0: latch FILL_BYTE and pulse tx_underrun.
    - Shift out MSB first on 8 falling edges. After the 8th falling edge, release SDA -> TX_ACK.
  - TX_ACK: sample SDA on the rising edge.
    - 0 (ACK): -> TX_BYTE on the next falling edge.
    - 1 (NACK): -> IGNORE.
  - RX_BYTE: shift in 8 bits -> RX_ACK.
  - RX_ACK: on the falling edge after bit 8:
    - rx_full=0: pulse rx_wr_en with rx_data = received byte, and drive ACK.
    - rx_full=1 and NACK_ON_FULL=1: drive NACK (release SDA) and pulse rx_overflow.
    - rx_full=1 and NACK_ON_FULL=0: drive ACK, pulse rx_overflow, no push.
    - Release SDA on the next falling edge -> RX_BYTE.
  - IGNORE: SDA released; wait for START or STOP.
- Latencies:
  - addr_hit: 1 clk after the 8th-bit sample.
  - tx_rd_en: exactly one pulse per transmitted real byte.
  - rx_wr_en: at most one pulse per received byte.
- Simultaneous events: START or STOP takes priority over any SCL edge detected in the same cycle.
- Counter: 4-bit bit counter that saturates at 8; no wrap.
- Bursts: length is unlimited.

Decomposition:
- Package i2c_pkg:
  - state enum type i2c_rw_state_t (IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, IGNORE);
  - constants I2C_RW_READ=1'b1 and I2C_RW_WRITE=1'b0.
- Sub-module i2c_cond_detect:
  - parametrised synchronizer (SYNC_STAGES);
  - outputs scl_rise, scl_fall, start_pulse, stop_pulse, sda_s, busy.

Test Plan:
- Write 0x84 (addr 0x42, W), then bytes 0xA5, 0x3C, then STOP; rx_full=0 -> ACK on address and both bytes, two rx_wr_en pulses with rx_data 0xA5 then 0x3C, addr_hit pulses once.
- Read 0x85 with TX FIFO holding 0x12, 0x34; master ACKs byte 1 and NACKs byte 2 -> SDA carries 0x12 then 0x34, exactly two tx_rd_en pulses, SDA released after the NACK.
- Read with an empty TX FIFO for 1 byte -> 0xFF on SDA, tx_underrun pulses once, no tx_rd_en.
- Address 0x90 (0x48, W) -> no ACK (SDA stays 1 on the 9th clock), no addr_hit, no FIFO activity until STOP.
- Write with rx_full=1, NACK_ON_FULL=1 -> address ACKed, data byte NACKed, rx_overflow pulses, no rx_wr_en.
- Write 0x84 + byte 0x55, then repeated START + 0x85 read, then assert rst_n=0 mid-read -> 0x55 pushed, read proceeds after the Sr, reset releases SDA at once and all outputs return to 0.
